// File: rtl/ssf_bank_regs.sv
// ssf_bank_regs: Sega SSF-style ROM bank registers at $A130F1..$A130FF.
// Bus strobes are synchronized into vclk, and a small FSM turns each lower-byte
// write into exactly one register commit. bank1..bank7 select the 512 KiB ROM
// page for each cart window; window 0 is fixed to page 0.
// Optional feature macro: SSF_SRAM_CTRL_EN adds the SRAM control register at
// index 0 ($A130F1, D0 = enable, D1 = write protect). Without the macro, SRAM is
// never mapped in and is reported as write-protected.
module ssf_bank_regs (
  input  logic       vclk,
  input  logic       vres,
  input  logic       tme,
  input  logic       lwr,
  input  logic       as,
  input  logic [1:7] cart_address,
  input  logic [7:0] cart_data_lo,
  input  logic [2:0] bank_index,
  output logic [7:0] rom_bank,
  output logic       bank_wr,
  output logic       sram_en,
  output logic       sram_wp
);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, WAIT_REL} state_e;

  logic [1:0] tme_sync_q, lwr_sync_q, as_sync_q;
  logic       tme_s, lwr_s, as_s;
  logic       wr_cond;
  logic [2:0] wr_idx;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       bank_wr_q, bank_wr_d;
  // Entry 0 is never written and stays 0, so window 0 always reads page 0.
  logic [7:0] bank_q [8];
  logic [7:0] bank_d [8];

`ifdef SSF_SRAM_CTRL_EN
  logic sram_en_q, sram_en_d;
  logic sram_wp_q, sram_wp_d;
`endif

  // Two-flop synchronizers for the asynchronous 68K strobes; idle level is high.
  always_ff @(posedge vclk or negedge vres) begin
    if (!vres) begin
      tme_sync_q <= 2'b11;
      lwr_sync_q <= 2'b11;
      as_sync_q  <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's
      // old value, which is what gives a true two-flop delay.
      tme_sync_q <= {tme_sync_q[0], tme};
      lwr_sync_q <= {lwr_sync_q[0], lwr};
      as_sync_q  <= {as_sync_q[0], as};
    end
  end

  assign tme_s   = tme_sync_q[1];
  assign lwr_s   = lwr_sync_q[1];
  assign as_s    = as_sync_q[1];
  assign wr_cond = ~tme_s & ~lwr_s & ~as_s & (&cart_address[4:7]);
  assign wr_idx  = {cart_address[3], cart_address[2], cart_address[1]};

  // Next-state logic: capture on the first qualified edge, confirm on the next
  // one, commit once, then wait for the strobe to be released.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    bank_wr_d = 1'b0;
    bank_d    = bank_q;
`ifdef SSF_SRAM_CTRL_EN
    sram_en_d = sram_en_q;
    sram_wp_d = sram_wp_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_cond) begin
          state_d = CAPTURE;
          idx_d   = wr_idx;
          data_d  = cart_data_lo;
        end
      end
      CAPTURE: begin
        if (wr_cond) begin
          // The register is written on the edge entering COMMIT, so the new
          // value is on rom_bank during the same cycle bank_wr is high.
          state_d = COMMIT;
          if (idx_q != 3'd0) begin
            bank_d[idx_q] = data_q;
            bank_wr_d     = 1'b1;
          end else begin
`ifdef SSF_SRAM_CTRL_EN
            sram_en_d = data_q[0];
            sram_wp_d = data_q[1];
            bank_wr_d = 1'b1;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT:   state_d = WAIT_REL;
      WAIT_REL: if (lwr_s || tme_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM state, holding registers, bank registers and registered outputs.
  always_ff @(posedge vclk or negedge vres) begin
    if (!vres) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      data_q    <= 8'h00;
      bank_wr_q <= 1'b0;
      // NOTE: the bank registers are loaded with the identity map at reset, so
      // they must stay flops with a reset value rather than a RAM.
      for (int i = 0; i < 8; i++) bank_q[i] <= 8'(i);
`ifdef SSF_SRAM_CTRL_EN
      sram_en_q <= 1'b0;
      sram_wp_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      bank_wr_q <= bank_wr_d;
      bank_q    <= bank_d;
`ifdef SSF_SRAM_CTRL_EN
      sram_en_q <= sram_en_d;
      sram_wp_q <= sram_wp_d;
`endif
    end
  end

  assign rom_bank = bank_q[bank_index];
  assign bank_wr  = bank_wr_q;

`ifdef SSF_SRAM_CTRL_EN
  assign sram_en = sram_en_q;
  assign sram_wp = sram_wp_q;
`else
  assign sram_en = 1'b0;
  assign sram_wp = 1'b1;
`endif

endmodule

// File: doc/ssf_bank_regs.md
SSF_BANK_REGS -- requirements
Module: ssf_bank_regs

Interface
REQ-001 SHALL have port vclk  input  1  68K clock; all state on its rising edge.
REQ-002 SHALL have port vres  input  1  system reset; asynchronous, active-low.
REQ-003 SHALL have port tme  input  1  active-low select for $A130xx.
REQ-004 SHALL have port lwr  input  1  active-low lower-byte write strobe.
REQ-005 SHALL have port as  input  1  active-low address strobe.
REQ-006 SHALL have port cart_address  input  [1:7]  byte address bits A1..A7.
REQ-007 SHALL have port cart_data_lo  input  8  lower data byte D7..D0.
REQ-008 SHALL have port bank_index  input  3  window select: cart A21..A19 from the mapper.
REQ-009 SHALL have port rom_bank  output  8  bank number for the selected window; drives mapper rom_address[18:25].
REQ-010 SHALL have port bank_wr  output  1  one-cycle pulse on every register commit.
REQ-011 SHALL have port sram_en  output  1  SRAM mapped in.
REQ-012 SHALL have port sram_wp  output  1  SRAM write-protected.

Function
REQ-013 SHALL pass tme, lwr and as through a 2-flop synchronizer each before any use.
- wr_cond = synced tme, lwr and as all low, and A7..A4 = 4'hF.
- Register index = {A3,A2,A1}.
- uwr is not a port; upper-byte writes are ignored.
REQ-014 SHALL run an FSM with states IDLE, CAPTURE, COMMIT, WAIT_REL.
- IDLE -> CAPTURE when wr_cond; index and cart_data_lo sampled into holding registers on that edge.
- CAPTURE -> COMMIT if wr_cond still true; otherwise back to IDLE with no write (glitch abort).
- COMMIT: update the target register and assert bank_wr for exactly this cycle; -> WAIT_REL unconditionally.
- WAIT_REL -> IDLE once synced lwr or tme is high.
- Consequence: one commit per bus write, however long the strobe is held.
REQ-015 SHALL map index 1..7 to bank1..bank7, all 8 bits; bank0 is not writable.
REQ-016 SHALL set rom_bank combinationally from bank_index.
- bank_index 0 -> 8'h00.
- bank_index n (n = 1..7) -> bankn.
REQ-017 SHALL, with index 0, apply behaviour per REQ-024/REQ-025.
REQ-018 SHALL make a committed value visible on rom_bank in the same cycle bank_wr is high.
- Write latency: lwr low to commit = 4 vclk edges (2 sync, CAPTURE, COMMIT).
REQ-019 SHALL write a repeated index with the same value normally: bank_wr still pulses and the value is unchanged.
REQ-020 SHALL NOT let a bank_index change while a write is in progress block or delay the write.

Reset
REQ-021 SHALL, while vres is low, force the following regardless of vclk:
- FSM = IDLE, synchronizers = inactive (high);
- bankn = n for n = 1..7 (identity map), bank_wr = 0, sram_en = 0, sram_wp = 0.
REQ-022 SHALL discard any in-flight write when reset is asserted; no commit occurs after release until a new falling lwr is synchronized.
REQ-023 SHALL have reset release take effect on the first vclk edge after vres goes high; registers hold their reset values until a write commits.

Configuration
REQ-024 SHALL, with macro SSF_SRAM_CTRL_EN defined, implement a control register at index 0 ($A130F1):
- sram_en = D0, sram_wp = D1 at commit;
- bank_wr pulses for index-0 commits as for bank commits.
REQ-025 SHALL, without SSF_SRAM_CTRL_EN, behave as follows:
- sram_en tied 0, sram_wp tied 1;
- index-0 writes run the full FSM sequence but change no state and produce no bank_wr pulse.

Verification
REQ-026 SHALL cover reset: vres low, then release -> rom_bank = 0,1,2..7 for bank_index 0..7; sram_en = 0; bank_wr = 0.
REQ-027 SHALL cover a bank write: address $A130F7 (index 3), data 8'h2A, lwr held 6 cycles -> exactly one bank_wr pulse on the 4th edge after lwr falls; bank_index = 3 -> rom_bank = 8'h2A.
REQ-028 SHALL cover a glitch abort: lwr low for 1 cycle between sampling edges (CAPTURE then abort) -> no bank_wr; all banks unchanged.
REQ-029 SHALL cover reset mid-write: vres asserted while the FSM is in CAPTURE for data 8'h55 to index 5 -> bank5 = 5 after release; no bank_wr.
REQ-030 SHALL cover address decoding: a write to $A130E3 (A7..A4 = E) -> ignored; a write with tme high -> ignored.
REQ-031 SHALL cover SRAM control: write 8'h03 to $A130F1 -> sram_en = 1, sram_wp = 1 when SSF_SRAM_CTRL_EN is defined; sram_en = 0, sram_wp = 1 and no bank_wr when it is not.
